// File: rtl/stream_frame_tagger.sv
// rtl/stream_frame_tagger.sv - passive AXI4-Stream video frame position tracker and lock monitor
module stream_frame_tagger #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int TIMEOUT  = 1048576,
    parameter int XW       = 10,
    parameter int YW       = 9
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic          tvalid,
    input  logic          tready,
    input  logic          tuser,
    input  logic          tlast,
    input  logic          err_clr,
    output logic          frame_start,
    output logic          control,
    output logic          frame_done,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          err_len,
    output logic          err_sof,
    output logic          err_timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
    localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {S_IDLE, S_HUNT, S_CHECK, S_LOCKED} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] pix_x_q, pix_x_d;
    logic [YW-1:0] pix_y_q, pix_y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          control_q, control_d;
    logic          done_q, done_d;
    logic          err_len_q, err_len_d;
    logic          err_sof_q, err_sof_d;
    logic          err_to_q, err_to_d;

    logic beat, at_origin, at_eol, at_last_line, sof_bad, len_bad;
    logic ev_len, ev_sof, ev_to;

    assign beat         = tvalid & tready;
    assign at_origin    = (pix_x_q == '0) && (pix_y_q == '0);
    assign at_eol       = (pix_x_q == X_LAST);
    assign at_last_line = (pix_y_q == Y_LAST);
    assign sof_bad      = tuser & ~at_origin;
    assign len_bad      = tlast ^ at_eol;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            cnt_q     <= '0;
            control_q <= 1'b0;
            done_q    <= 1'b0;
            err_len_q <= 1'b0;
            err_sof_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            cnt_q     <= cnt_d;
            control_q <= control_d;
            done_q    <= done_d;
            err_len_q <= err_len_d;
            err_sof_q <= err_sof_d;
            err_to_q  <= err_to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pix_x_d = pix_x_q;
        pix_y_d = pix_y_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ev_len  = 1'b0;
        ev_sof  = 1'b0;
        ev_to   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_HUNT;
            end
            S_HUNT: begin
                // The SOF beat is treated as (0,0); a tlast on it is a short line.
                if (beat && tuser) begin
                    if (tlast) begin
                        ev_len = 1'b1;
                    end else begin
                        state_d = S_CHECK;
                        pix_x_d = XW'(1);
                        pix_y_d = '0;
                    end
                end
            end
            default: begin
                if (!tvalid) begin
                    if (cnt_q < TO_MAX) cnt_d = cnt_q + 1'b1;
                    if (cnt_q >= TO_LAST) begin
                        ev_to   = 1'b1;
                        state_d = S_HUNT;
                        pix_x_d = '0;
                        pix_y_d = '0;
                    end
                end else begin
                    cnt_d = '0;
                end
                if (beat) begin
                    if (sof_bad) begin
                        // Early SOF restarts the frame on this beat, even if tlast is also wrong.
                        ev_sof  = 1'b1;
                        ev_len  = len_bad;
                        state_d = S_CHECK;
                        pix_x_d = XW'(1);
                        pix_y_d = '0;
                    end else if (len_bad) begin
                        ev_len  = 1'b1;
                        state_d = S_HUNT;
                        pix_x_d = '0;
                        pix_y_d = '0;
                    end else if (at_eol) begin
                        pix_x_d = '0;
                        if (at_last_line) begin
                            done_d  = 1'b1;
                            state_d = S_LOCKED;
                            pix_y_d = '0;
                        end else begin
                            pix_y_d = pix_y_q + 1'b1;
                        end
                    end else begin
                        pix_x_d = pix_x_q + 1'b1;
                    end
                end
            end
        endcase
        if (!enable) begin
            state_d = S_IDLE;
            pix_x_d = '0;
            pix_y_d = '0;
            done_d  = 1'b0;
            ev_len  = 1'b0;
            ev_sof  = 1'b0;
            ev_to   = 1'b0;
        end
        if (state_d == S_IDLE || state_d == S_HUNT) cnt_d = '0;
    end

    always_comb begin
        control_d   = (state_d == S_LOCKED);
        err_len_d   = (err_len_q & ~err_clr) | ev_len;
        err_sof_d   = (err_sof_q & ~err_clr) | ev_sof;
        err_to_d    = (err_to_q & ~err_clr) | ev_to;
        frame_start = tvalid & tuser & (state_q != S_IDLE);
        control     = control_q;
        frame_done  = done_q;
        pix_x       = pix_x_q;
        pix_y       = pix_y_q;
        err_len     = err_len_q;
        err_sof     = err_sof_q;
        err_timeout = err_to_q;
    end

endmodule
